nios2_oci_dct_packer: RTL and testbench

- Sequencer for the OCI direct-control-transfer (DCT) trace datapath.
- Collects 2-bit DCT fragments from the CPU into a 30-bit buffer (15 fragments).
- Hands each full or flushed buffer, with its fragment count, to the trace store over a valid/ready handshake.
- Exposes the live dct_buffer/dct_count to the OCI test bench; counts fragments dropped under back-pressure.

---
 rtl/nios2_oci_dct_pkg.sv | 37 +++
 rtl/nios2_oci_dct_hold.sv | 31 +++
 rtl/nios2_oci_dct_packer.sv | 143 ++++++++++++++
 tb/tb_nios2_oci_dct_packer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants, state encoding and word type for the OCI DCT trace packer.
package nios2_oci_dct_pkg;

  localparam int FRAG_W = 2;
  localparam int FRAGS  = 15;
  localparam int BUF_W  = FRAG_W * FRAGS;
  localparam int CNT_W  = 4;
  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    FULL_WAIT = 2'd2,
    DRAIN     = 2'd3
  } dct_state_e;

  // One emitted trace word: fragment count alongside the packed buffer.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] data;
  } dct_word_t;

  // Write a fragment into slot idx of an accumulator, leaving other slots alone.
  function automatic logic [BUF_W-1:0] dct_place(
    input logic [BUF_W-1:0]  acc_in,
    input logic [CNT_W-1:0]  idx,
    input logic [FRAG_W-1:0] code
  );
    logic [BUF_W-1:0] r;
    r = acc_in;
    for (int i = 0; i < FRAGS; i++) begin
      if (idx == CNT_W'(i)) r[i*FRAG_W +: FRAG_W] = code;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios2_oci_dct_hold.sv
// Single-entry valid/ready holding register. The loader only loads when free,
// so a load in a handshake cycle replaces the word with no bubble.
module nios2_oci_dct_hold
  import nios2_oci_dct_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  dct_word_t load_word,
  input  logic      ready,
  output logic      valid,
  output dct_word_t word,
  output logic      free
);

  assign free = !valid || ready;

  // Capture on load; otherwise drop valid once the consumer takes the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit DCT fragments into 30-bit trace words and hands them to the
// trace store; drops and counts fragments while a full buffer is stuck.
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_en,
  input  logic              dct_valid,
  input  logic [FRAG_W-1:0] dct_code,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);

  dct_state_e       state, state_nxt;
  logic [BUF_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load, hold_free, flush_pend, flush_pend_nxt;
  dct_word_t        load_word, hold_word;
  logic             trace_en_q;

  // IDLE behaves like ACTIVE for accumulation; it only differs in trace_en=0.
  logic acc_state, full, frag_in, accept, drop, flush_req, en_rise;
  assign acc_state = (state == IDLE) || (state == ACTIVE);
  assign full      = (dct_count == CNT_W'(FRAGS));
  assign frag_in   = dct_valid && trace_en;
  // A full accumulator can still take a fragment in its transfer cycle.
  assign accept    = frag_in && acc_state && (!full || hold_free);
  assign drop      = frag_in && ((state == FULL_WAIT) || (acc_state && full && !hold_free));
  // A flush that finds the holding register busy is remembered until it can go.
  assign flush_req = flush || flush_pend;
  assign en_rise   = trace_en && !trace_en_q;

  nios2_oci_dct_hold u_hold (
    .clk       (clk),
    .rst_n     (reset_n),
    .load      (load),
    .load_word (load_word),
    .ready     (out_ready),
    .valid     (out_valid),
    .word      (hold_word),
    .free      (hold_free)
  );

  assign out_data  = hold_word.data;
  assign out_count = hold_word.count;
  assign busy      = (dct_count != '0) || out_valid;

  // Next state, accumulator update and holding-register load decision.
  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    load_word      = '{count: dct_count, data: dct_buffer};
    acc_nxt        = dct_buffer;
    cnt_nxt        = dct_count;
    flush_pend_nxt = 1'b0;
    case (state)
      IDLE, ACTIVE: begin
        if (full) begin
          // Full word emits whole; a same-cycle fragment starts the next word.
          if (hold_free) begin
            load    = 1'b1;
            acc_nxt = '0;
            cnt_nxt = '0;
            if (accept) begin
              acc_nxt = dct_place('0, '0, dct_code);
              cnt_nxt = CNT_W'(1);
            end
          end
        end else begin
          if (accept) begin
            acc_nxt = dct_place(dct_buffer, dct_count, dct_code);
            cnt_nxt = dct_count + CNT_W'(1);
          end
          // Flush includes the fragment accepted in the same cycle.
          if (flush_req && (cnt_nxt != '0)) begin
            if (hold_free) begin
              load      = 1'b1;
              load_word = '{count: cnt_nxt, data: acc_nxt};
              acc_nxt   = '0;
              cnt_nxt   = '0;
            end else begin
              flush_pend_nxt = 1'b1;
            end
          end
        end
        if (full && !hold_free)  state_nxt = FULL_WAIT;
        else if (!trace_en)      state_nxt = (cnt_nxt != '0) ? DRAIN : IDLE;
        else                     state_nxt = ACTIVE;
      end
      FULL_WAIT, DRAIN: begin
        // Both wait only for the holding register; re-enable resumes after.
        if (hold_free) begin
          load      = 1'b1;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = trace_en ? ACTIVE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator and pending-flush registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      trace_en_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      dct_buffer <= acc_nxt;
      dct_count  <= cnt_nxt;
      flush_pend <= flush_pend_nxt;
      trace_en_q <= trace_en;
    end
  end

  // Sticky overflow and saturating drop count, cleared on trace enable rising.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (en_rise) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed bench: stimulus pushes expected words, a negedge monitor pops and
// compares every accepted output word; state checks are inline.
module tb_nios2_oci_dct_packer;
  import nios2_oci_dct_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              trace_en = 1'b0;
  logic              dct_valid = 1'b0;
  logic [FRAG_W-1:0] dct_code = '0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b1;
  logic              out_valid;
  logic [BUF_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic              busy;

  int        errors = 0;
  int        checks = 0;
  dct_word_t exp_q[$];
  dct_word_t mon_e;

  always #5 clk = ~clk;

  nios2_oci_dct_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trace_en   (trace_en),
    .dct_valid  (dct_valid),
    .dct_code   (dct_code),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic frags(input int n, input logic [1:0] c);
    for (int i = 0; i < n; i++) begin
      dct_valid = 1'b1;
      dct_code  = c;
      tick();
    end
    dct_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic expect_word(input int cnt, input logic [29:0] d);
    exp_q.push_back('{count: CNT_W'(cnt), data: d});
  endtask

  // Scoreboard monitor: every accepted word must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got count=%0d data=%h, expected no word", out_count, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_count !== mon_e.count || out_data !== mon_e.data) begin
          errors++;
          $display("FAIL word: got count=%0d data=%h, expected count=%0d data=%h",
                   out_count, out_data, mon_e.count, mon_e.data);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    trace_en = 1'b1;

    // Fill: 15 x 01 emits one cycle after the 15th fragment
    expect_word(15, 30'h15555555);
    frags(15, 2'b01);
    chk("fill_count15", 32'(dct_count), 32'd15);
    chk("fill_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("fill_valid", 32'(out_valid), 32'd1);
    chk("fill_data", 32'(out_data), 32'h15555555);
    chk("fill_cnt_clr", 32'(dct_count), 32'd0);
    tick();
    chk("fill_valid_clr", 32'(out_valid), 32'd0);

    // Back-pressure: second buffer stuck, three fragments dropped
    out_ready = 1'b0;
    expect_word(15, 30'h2AAAAAAA);
    expect_word(15, 30'h2AAAAAAA);
    frags(33, 2'b10);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_drop", 32'(drop_count), 32'd3);
    chk("bp_count", 32'(dct_count), 32'd15);
    chk("bp_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_b2b_valid", 32'(out_valid), 32'd1);
    chk("bp_acc_clr", 32'(dct_count), 32'd0);
    tick();
    chk("bp_done", 32'(out_valid), 32'd0);

    // Flush partial, then an empty flush that must emit nothing
    frags(1, 2'b11); frags(1, 2'b00); frags(1, 2'b01);
    expect_word(3, 30'h13);
    do_flush();
    chk("fl_valid", 32'(out_valid), 32'd1);
    chk("fl_count", 32'(out_count), 32'd3);
    chk("fl_acc_clr", 32'(dct_count), 32'd0);
    do_flush();
    tick();
    chk("fl_empty_noop", 32'(out_valid), 32'd0);
    chk("fl_keeps_ovf", 32'(overflow), 32'd1);
    chk("fl_keeps_drop", 32'(drop_count), 32'd3);

    // 15th fragment together with flush: exactly one word
    expect_word(15, 30'h2AAAAAAA);
    frags(14, 2'b10);
    dct_valid = 1'b1; dct_code = 2'b10; flush = 1'b1;
    tick();
    dct_valid = 1'b0; flush = 1'b0;
    chk("sim_valid", 32'(out_valid), 32'd1);
    chk("sim_count", 32'(out_count), 32'd15);
    chk("sim_acc_clr", 32'(dct_count), 32'd0);
    tick();
    chk("sim_one_word", 32'(out_valid), 32'd0);

    // Fragment in the transfer cycle becomes fragment 0 of the next word
    expect_word(15, 30'h3FFFFFFF);
    expect_word(1, 30'h1);
    frags(15, 2'b11);
    frags(1, 2'b01);
    chk("xfer_valid", 32'(out_valid), 32'd1);
    chk("xfer_count1", 32'(dct_count), 32'd1);
    chk("xfer_buf", 32'(dct_buffer), 32'h1);
    do_flush();
    chk("xfer_flush_cnt", 32'(out_count), 32'd1);
    tick();
    chk("xfer_done", 32'(out_valid), 32'd0);

    // Disable mid-word with the holding register occupied
    out_ready = 1'b0;
    expect_word(2, 30'hA);
    expect_word(5, 30'h155);
    frags(2, 2'b10);
    do_flush();
    frags(5, 2'b01);
    trace_en = 1'b0;
    dct_valid = 1'b1; dct_code = 2'b11;
    tick(); tick(); tick(); tick();
    chk("dr_count", 32'(dct_count), 32'd5);
    chk("dr_buf", 32'(dct_buffer), 32'h155);
    chk("dr_hold_cnt", 32'(out_count), 32'd2);
    chk("dr_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("dr_b2b", 32'(out_valid), 32'd1);
    chk("dr_cnt5", 32'(out_count), 32'd5);
    chk("dr_acc_clr", 32'(dct_count), 32'd0);
    tick();
    chk("dr_idle_valid", 32'(out_valid), 32'd0);
    chk("dr_idle_busy", 32'(busy), 32'd0);
    chk("dr_ignored", 32'(dct_count), 32'd0);
    dct_valid = 1'b0;
    chk("dr_ovf_kept", 32'(overflow), 32'd1);
    trace_en = 1'b1;
    tick();
    chk("en_ovf_clr", 32'(overflow), 32'd0);
    chk("en_drop_clr", 32'(drop_count), 32'd0);

    // Asynchronous reset mid-word: nothing emitted afterwards
    out_ready = 1'b0;
    frags(1, 2'b01);
    do_flush();
    frags(7, 2'b10);
    chk("rs_pre_count", 32'(dct_count), 32'd7);
    chk("rs_pre_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_count", 32'(dct_count), 32'd0);
    chk("rs_buf", 32'(dct_buffer), 32'd0);
    chk("rs_data", 32'(out_data), 32'd0);
    chk("rs_ocount", 32'(out_count), 32'd0);
    out_ready = 1'b1;
    trace_en = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rs_no_emit", 32'(out_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
